// File: rtl/chunk_receiver.sv
// Receive side of the 4-phase req/ack chunk link: synchronises req, captures LSB-first
// chunks, acknowledges each one, and publishes the reassembled datagram with a valid strobe.
module chunk_receiver #(
    parameter int N           = 16,
    parameter int CHUNK_W     = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wire_req,
    input  logic [CHUNK_W-1:0] wire_data_deliver,
    output logic               reg_ack,
    output logic [N-1:0]       wire_data_out,
    output logic               reg_valid,
    output logic               reg_frame_err
);

    localparam int NCHUNK = (N + CHUNK_W - 1) / CHUNK_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                 state_q, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [CNT_W-1:0]       cnt_q, cnt_n, slot;
    logic [TMR_W-1:0]       tmr_q, tmr_n;
    logic [N-1:0]           asm_q, asm_n;
    logic [N-1:0]           data_n;
    logic                   ack_n, valid_n, err_n;
    logic                   timeout;

    // Only the synchronised req drives logic; data is sampled raw because the
    // sender holds it stable across the whole capture window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], wire_req};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    assign timeout = (state_q == IDLE) && (cnt_q != '0) && (tmr_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        tmr_n   = tmr_q;
        asm_n   = asm_q;
        data_n  = wire_data_out;
        ack_n   = 1'b0;
        valid_n = 1'b0;
        err_n   = 1'b0;
        slot    = timeout ? '0 : cnt_q;
        case (state_q)
            IDLE: begin
                if (req_s || cnt_q == '0 || timeout) tmr_n = '0;
                else                                 tmr_n = tmr_q + TMR_W'(1);
                if (timeout) begin
                    cnt_n = '0;
                    err_n = 1'b1;
                end
                // A capture on the expiry edge resyncs: that chunk lands in slot 0.
                if (req_s) begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (slot == CNT_W'(i)) begin
                            for (int b = 0; b < CHUNK_W; b++) begin
                                if (i * CHUNK_W + b < N) asm_n[i * CHUNK_W + b] = wire_data_deliver[b];
                            end
                        end
                    end
                    state_n = ACK;
                    ack_n   = 1'b1;
                end
            end
            ACK: begin
                ack_n = 1'b1;
                tmr_n = '0;
                if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                    if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                        data_n  = asm_q;
                        valid_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tmr_q         <= '0;
            asm_q         <= '0;
            reg_ack       <= 1'b0;
            wire_data_out <= '0;
            reg_valid     <= 1'b0;
            reg_frame_err <= 1'b0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            tmr_q         <= tmr_n;
            asm_q         <= asm_n;
            reg_ack       <= ack_n;
            wire_data_out <= data_n;
            reg_valid     <= valid_n;
            reg_frame_err <= err_n;
        end
    end

endmodule

// File: tb/tb_chunk_receiver.sv
// Scoreboard bench for chunk_receiver: a sender model drives 4-phase handshakes and
// queues expected datagrams; a monitor pops and compares on every reg_valid pulse.
module tb_chunk_receiver;

    localparam int N       = 16;
    localparam int CW      = 6;
    localparam int NCH     = 3;
    localparam int TIMEOUT = 1024;
    localparam int LIM     = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wire_req = 1'b0;
    logic [CW-1:0] wire_data_deliver = '0;
    logic          reg_ack;
    logic [N-1:0]  wire_data_out;
    logic          reg_valid;
    logic          reg_frame_err;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0, err_cnt = 0;
    int exp_valid = 0, exp_err = 0;

    logic [N-1:0] exp_q[$];
    int           mdl_idx = 0;
    logic [23:0]  mdl_acc = '0;
    logic [N-1:0] last_out = '0;

    chunk_receiver #(.N(N), .CHUNK_W(CW), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wire_req(wire_req), .wire_data_deliver(wire_data_deliver),
        .reg_ack(reg_ack), .wire_data_out(wire_data_out), .reg_valid(reg_valid),
        .reg_frame_err(reg_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued datagram.
    always @(negedge clk) begin
        if (rst && reg_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: got 0x%0h expected none", wire_data_out);
            end else begin
                chk("datagram", 32'(wire_data_out), 32'(exp_q.pop_front()));
            end
        end
        if (rst && reg_frame_err) err_cnt++;
    end

    // Model: chunk k contributes its bits at k*CW, truncated to N on completion.
    task automatic model_chunk(input logic [CW-1:0] d);
        mdl_acc = mdl_acc | (24'(d) << (mdl_idx * CW));
        mdl_idx++;
        if (mdl_idx == NCH) begin
            last_out = mdl_acc[N-1:0];
            exp_q.push_back(last_out);
            exp_valid++;
            mdl_idx = 0;
            mdl_acc = '0;
        end
    endtask

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        while (reg_ack !== lvl && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (reg_ack !== lvl) begin
            total++; bad++;
            $display("FAIL ack_wait: got %0b expected %0b after %0d cycles", reg_ack, lvl, n);
        end
    endtask

    task automatic send_chunk(input logic [CW-1:0] d, input int pre, input int hold,
                              input bit scramble, output int rise, output int fall);
        repeat (pre) @(negedge clk);
        wire_data_deliver = d;
        wire_req = 1'b1;
        wait_ack(1'b1, rise);
        if (scramble) wire_data_deliver = ~d;
        repeat (hold) @(negedge clk);
        wire_req = 1'b0;
        wait_ack(1'b0, fall);
        model_chunk(d);
    endtask

    task automatic send_frame(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                              input logic [CW-1:0] c2);
        int r, f;
        send_chunk(c0, 0, 0, 1'b0, r, f);
        send_chunk(c1, 0, 0, 1'b0, r, f);
        send_chunk(c2, 0, 0, 1'b0, r, f);
    endtask

    initial begin
        int r, f;
        logic [CW-1:0] chunks[3];
        chunks[0] = 6'h2A; chunks[1] = 6'h15; chunks[2] = 6'h0F;

        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(reg_ack), 32'd0);
        chk("reset_out", 32'(wire_data_out), 32'd0);
        chk("reset_valid", 32'(reg_valid), 32'd0);
        chk("reset_err", 32'(reg_frame_err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame with latency checks on every handshake edge.
        for (int k = 0; k < NCH; k++) begin
            send_chunk(chunks[k], 1, 1, 1'b0, r, f);
            chk("ack_rise_latency", 32'(r), 32'd3);
            chk("ack_fall_latency", 32'(f), 32'd3);
        end
        repeat (2) @(negedge clk);
        chk("frame1_out", 32'(wire_data_out), 32'hF56A);

        // Back-to-back: output holds the previous datagram until the final ack fall.
        send_frame(6'h2A, 6'h15, 6'h0F);
        send_chunk(6'h01, 0, 0, 1'b0, r, f);
        send_chunk(6'h00, 0, 0, 1'b0, r, f);
        wire_data_deliver = 6'h00;
        wire_req = 1'b1;
        wait_ack(1'b1, r);
        chk("hold_between_frames", 32'(wire_data_out), 32'hF56A);
        wire_req = 1'b0;
        wait_ack(1'b0, f);
        model_chunk(6'h00);
        @(negedge clk);
        chk("frame_b2b_out", 32'(wire_data_out), 32'h0001);

        // Partial frame left idle: no error before expiry, one after, output untouched.
        send_chunk(6'h11, 0, 0, 1'b0, r, f);
        send_chunk(6'h22, 0, 0, 1'b0, r, f);
        repeat (TIMEOUT - 20) @(negedge clk);
        chk("no_early_timeout", 32'(err_cnt), 32'd0);
        repeat (40) @(negedge clk);
        mdl_idx = 0; mdl_acc = '0; exp_err++;
        chk("timeout_err", 32'(err_cnt), 32'd1);
        chk("timeout_out_held", 32'(wire_data_out), 32'h0001);
        send_frame(6'h3F, 6'h3F, 6'h3F);
        @(negedge clk);
        chk("resync_out", 32'(wire_data_out), 32'hFFFF);

        // Async reset while chunk 1 is in its ACK phase.
        send_chunk(6'h05, 0, 0, 1'b0, r, f);
        wire_data_deliver = 6'h06;
        wire_req = 1'b1;
        wait_ack(1'b1, r);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ack", 32'(reg_ack), 32'd0);
        chk("async_rst_out", 32'(wire_data_out), 32'd0);
        wire_req = 1'b0;
        mdl_idx = 0; mdl_acc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(6'h2A, 6'h15, 6'h0F);
        @(negedge clk);
        chk("post_reset_out", 32'(wire_data_out), 32'hF56A);

        // Long req hold with data scrambled after ack: ack must stay high, no capture.
        wire_data_deliver = 6'h07;
        wire_req = 1'b1;
        wait_ack(1'b1, r);
        wire_data_deliver = 6'h38;
        begin
            int drops = 0;
            repeat (50) begin
                @(negedge clk);
                if (reg_ack !== 1'b1) drops++;
            end
            chk("ack_held_50", 32'(drops), 32'd0);
        end
        wire_req = 1'b0;
        wait_ack(1'b0, f);
        model_chunk(6'h07);
        send_chunk(6'h3C, 0, 0, 1'b1, r, f);
        send_chunk(6'h01, 0, 0, 1'b1, r, f);
        @(negedge clk);
        chk("long_hold_out", 32'(wire_data_out), 32'h1F07);

        // Randomised sender timing and data.
        for (int fr = 0; fr < 200; fr++) begin
            for (int k = 0; k < NCH; k++) begin
                send_chunk(CW'($urandom), $urandom_range(0, 20), $urandom_range(0, 20),
                           1'($urandom_range(0, 1)), r, f);
            end
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("valid_count", 32'(valid_cnt), 32'(exp_valid));
        chk("err_count", 32'(err_cnt), 32'(exp_err));
        chk("final_out", 32'(wire_data_out), 32'(last_out));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
